// File: rtl/motor_dir_sequencer.sv
// motor_dir_sequencer: single-motor speed/direction sequencer for an L298 bridge.
// Synchronises eight switch requests, priority-encodes them into a duty target
// and direction, ramps the duty command, and reverses the bridge only after the
// duty has reached zero and a dead time has elapsed.
//
// Ports:
//   w5     in   system clock, all flops rise on it
//   u18    in   asynchronous active-high reset
//   sw     in   [0..3] forward 100/75/50/25 %, [4..7] reverse 100/75/50/25 %
//   estop  in   emergency stop, level-sensitive, active-high
//   duty   out  duty command in percent (0..100)
//   en_a   out  bridge enable
//   in1    out  L298 IN1
//   in2    out  L298 IN2
//   dir    out  applied direction, 0 = forward, 1 = reverse
//   busy   out  high while ramping or in dead time
module motor_dir_sequencer #(
   parameter int unsigned RAMP_DIV    = 100000,
   parameter int unsigned RAMP_STEP   = 5,
   parameter int unsigned DEAD_CYCLES = 100000
) (
   input  logic       w5,
   input  logic       u18,
   input  logic [7:0] sw,
   input  logic       estop,
   output logic [7:0] duty,
   output logic       en_a,
   output logic       in1,
   output logic       in2,
   output logic       dir,
   output logic       busy
);

   localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned DW = $clog2(DEAD_CYCLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RAMP = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DEAD = 2'd3;

   logic [7:0]    sw_s1, sw_s2;
   logic          estop_s1, estop_s2;
   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic [7:0]    req_duty;
   logic          req_dir;
   logic [7:0]    goal;
   logic [7:0]    step;
   logic [7:0]    duty_step;

   logic [1:0]    state, state_n;
   logic [DW-1:0] dead_cnt, dead_n;
   logic [7:0]    duty_n;
   logic          dir_n, en_n, in1_n, in2_n, busy_n;

   // Two-flop synchronisers for the asynchronous switch and estop inputs
   always_ff @(posedge w5 or posedge u18) begin
      if (u18) begin
         sw_s1    <= '0;
         sw_s2    <= '0;
         estop_s1 <= 1'b0;
         estop_s2 <= 1'b0;
      end else begin
         sw_s1    <= sw;
         sw_s2    <= sw_s1;
         estop_s1 <= estop;
         estop_s2 <= estop_s1;
      end
   end

   // Free-running ramp prescaler
   always_ff @(posedge w5 or posedge u18) begin
      if (u18)       pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + PW'(1);
   end

   assign tick = (pre_cnt == PW'(RAMP_DIV - 1));

   // Lowest set switch wins; no request keeps the current direction
   always_comb begin
      req_duty = 8'd0;
      req_dir  = dir;
      casez (sw_s2)
         8'b???????1: begin req_duty = 8'd100; req_dir = 1'b0; end
         8'b??????10: begin req_duty = 8'd75;  req_dir = 1'b0; end
         8'b?????100: begin req_duty = 8'd50;  req_dir = 1'b0; end
         8'b????1000: begin req_duty = 8'd25;  req_dir = 1'b0; end
         8'b???10000: begin req_duty = 8'd100; req_dir = 1'b1; end
         8'b??100000: begin req_duty = 8'd75;  req_dir = 1'b1; end
         8'b?1000000: begin req_duty = 8'd50;  req_dir = 1'b1; end
         8'b10000000: begin req_duty = 8'd25;  req_dir = 1'b1; end
         default:     begin req_duty = 8'd0;   req_dir = dir;  end
      endcase
   end

   // A request for the opposite direction first drives the duty to zero
   assign goal = (req_dir == dir) ? req_duty : 8'd0;
   assign step = 8'(RAMP_STEP);

   // One ramp step toward goal, saturating so it never passes goal
   always_comb begin
      duty_step = duty;
      if (duty < goal) begin
         duty_step = ((goal - duty) > step) ? (duty + step) : goal;
      end else if (duty > goal) begin
         duty_step = ((duty - goal) > step) ? (duty - step) : goal;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n = state;
      duty_n  = duty;
      dir_n   = dir;
      dead_n  = dead_cnt;

      case (state)
         S_IDLE: begin
            duty_n = 8'd0;
            if (req_duty != 8'd0) begin
               dir_n   = req_dir;
               state_n = S_RAMP;
            end
         end
         S_RAMP: begin
            if ((duty == goal) && (goal != 8'd0)) begin
               state_n = S_HOLD;
            end else if ((duty == 8'd0) && (goal == 8'd0)) begin
               state_n = S_DEAD;
               dead_n  = DW'(DEAD_CYCLES);
            end else if (tick) begin
               duty_n = duty_step;
            end
         end
         S_HOLD: begin
            if (goal != duty) state_n = S_RAMP;
         end
         S_DEAD: begin
            duty_n = 8'd0;
            // Counter holds DEAD_CYCLES on entry, so expiry on 1 gives exactly that many cycles
            if (dead_cnt <= DW'(1)) begin
               if (req_duty == 8'd0) begin
                  state_n = S_IDLE;
               end else begin
                  dir_n   = req_dir;
                  state_n = S_RAMP;
               end
            end else begin
               dead_n = dead_cnt - DW'(1);
            end
         end
         default: begin
            state_n = S_IDLE;
            duty_n  = 8'd0;
         end
      endcase

      // Emergency stop overrides everything and keeps the dead counter reloaded
      if (estop_s2) begin
         state_n = S_DEAD;
         duty_n  = 8'd0;
         dir_n   = dir;
         dead_n  = DW'(DEAD_CYCLES);
      end

      en_n   = (state_n == S_RAMP) || (state_n == S_HOLD);
      in1_n  = en_n & ~dir_n;
      in2_n  = en_n & dir_n;
      busy_n = (state_n == S_RAMP) || (state_n == S_DEAD);
   end

   // State and registered outputs update together
   always_ff @(posedge w5 or posedge u18) begin
      if (u18) begin
         state    <= S_IDLE;
         duty     <= 8'd0;
         dir      <= 1'b0;
         dead_cnt <= '0;
         en_a     <= 1'b0;
         in1      <= 1'b0;
         in2      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_n;
         duty     <= duty_n;
         dir      <= dir_n;
         dead_cnt <= dead_n;
         en_a     <= en_n;
         in1      <= in1_n;
         in2      <= in2_n;
         busy     <= busy_n;
      end
   end

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// tb_motor_dir_sequencer: scoreboard bench for motor_dir_sequencer.
// Expected output vectors (with the number of cycles each must persist) are
// queued when a request is driven; a monitor pops one entry per observed
// change of {busy, dir, in1, in2, en_a, duty}.
module tb_motor_dir_sequencer;

   localparam int unsigned RAMP_DIV    = 4;
   localparam int unsigned RAMP_STEP   = 25;
   localparam int unsigned DEAD_CYCLES = 8;

   logic       w5;
   logic       u18;
   logic [7:0] sw;
   logic       estop;
   logic [7:0] duty;
   logic       en_a, in1, in2, dir, busy;

   motor_dir_sequencer #(
      .RAMP_DIV    (RAMP_DIV),
      .RAMP_STEP   (RAMP_STEP),
      .DEAD_CYCLES (DEAD_CYCLES)
   ) dut (
      .w5    (w5),
      .u18   (u18),
      .sw    (sw),
      .estop (estop),
      .duty  (duty),
      .en_a  (en_a),
      .in1   (in1),
      .in2   (in2),
      .dir   (dir),
      .busy  (busy)
   );

   typedef struct {
      logic [12:0] v;
      int          dw;   // cycles this vector must persist, 0 = not checked
   } exp_t;

   exp_t        q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   logic        mon_en   = 1'b0;
   logic [12:0] last     = '0;
   int          prev_dw  = 0;
   int          prev_cyc = 0;
   logic [12:0] outvec;

   assign outvec = {busy, dir, in1, in2, en_a, duty};

   initial w5 = 1'b0;
   always #5 w5 = ~w5;

   always @(posedge w5) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected output vector: bridge pins follow enable and direction
   function automatic logic [12:0] ov(input logic b, input logic d, input logic e, input logic [7:0] du);
      return {b, d, e & ~d, e & d, e, du};
   endfunction

   task automatic push(input logic [12:0] v, input int dw);
      exp_t e;
      e.v  = v;
      e.dw = dw;
      q.push_back(e);
   endtask

   // From duty 0 (IDLE or DEAD) up to target t, ending in HOLD
   task automatic push_up(input logic d, input int t);
      push(ov(1'b1, d, 1'b1, 8'd0), 0);
      for (int x = RAMP_STEP; x < t; x += RAMP_STEP) push(ov(1'b1, d, 1'b1, 8'(x)), RAMP_DIV);
      push(ov(1'b1, d, 1'b1, 8'(t)), 1);
      push(ov(1'b0, d, 1'b1, 8'(t)), 0);
   endtask

   // From HOLD at h to a new nonzero target t in the same direction
   task automatic push_retarget(input logic d, input int h, input int t);
      push(ov(1'b1, d, 1'b1, 8'(h)), 0);
      if (t > h) begin
         for (int x = h + RAMP_STEP; x < t; x += RAMP_STEP) push(ov(1'b1, d, 1'b1, 8'(x)), RAMP_DIV);
      end else begin
         for (int x = h - RAMP_STEP; x > t; x -= RAMP_STEP) push(ov(1'b1, d, 1'b1, 8'(x)), RAMP_DIV);
      end
      push(ov(1'b1, d, 1'b1, 8'(t)), 1);
      push(ov(1'b0, d, 1'b1, 8'(t)), 0);
   endtask

   // From HOLD at h down to 0, then the full dead time
   task automatic push_down(input logic d, input int h);
      push(ov(1'b1, d, 1'b1, 8'(h)), 0);
      for (int x = h - RAMP_STEP; x > 0; x -= RAMP_STEP) push(ov(1'b1, d, 1'b1, 8'(x)), RAMP_DIV);
      push(ov(1'b1, d, 1'b1, 8'd0), 1);
      push(ov(1'b1, d, 1'b0, 8'd0), DEAD_CYCLES);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (q.size() != 0 && n < 400) begin
         @(negedge w5);
         n++;
      end
      check({"drain_", tag}, q.size(), 0);
      repeat (6) @(negedge w5);
   endtask

   // Output monitor: every change must match the next queued vector
   initial begin
      wait (mon_en);
      forever begin
         @(negedge w5);
         if (outvec !== last) begin
            if (q.size() == 0) begin
               check("unexpected_change", outvec, last);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (prev_dw != 0) check("dwell", cyc - prev_cyc, prev_dw);
               check("output", outvec, e.v);
               prev_dw  = e.dw;
               prev_cyc = cyc;
            end
            last = outvec;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      u18   = 1'b1;
      sw    = 8'h00;
      estop = 1'b0;
      repeat (3) @(negedge w5);
      check("reset_outputs", outvec, 0);
      u18 = 1'b0;
      repeat (3) @(negedge w5);
      check("idle_after_reset", outvec, 0);
      mon_en = 1'b1;

      // Forward ramp with switch-to-reaction latency
      push_up(1'b0, 100);
      sw = 8'h01;
      @(posedge w5);
      @(posedge w5);
      #1 check("latency_edge2", {en_a, in1, in2}, 3'b000);
      @(posedge w5);
      #1 check("latency_edge3", {en_a, in1, in2}, 3'b110);
      drain("fwd_ramp");

      // Priority: bit 0 still wins over bit 1, nothing changes
      sw = 8'h03;
      repeat (20) @(negedge w5);
      check("priority_hold", outvec, ov(1'b0, 1'b0, 1'b1, 8'd100));
      drain("priority");

      // Partial ramp down in the same direction, no dead time
      push_retarget(1'b0, 100, 25);
      sw = 8'h08;
      drain("partial_down");

      push_retarget(1'b0, 25, 50);
      sw = 8'h04;
      drain("partial_up");

      // Stop from 50
      push_down(1'b0, 50);
      push(ov(1'b0, 1'b0, 1'b0, 8'd0), 0);
      sw = 8'h00;
      drain("stop");

      push_up(1'b0, 100);
      sw = 8'h01;
      drain("fwd_again");

      // Reversal: down to zero, dead time, then up in reverse
      push_down(1'b0, 100);
      push_up(1'b1, 100);
      sw = 8'h10;
      drain("reverse");
      check("reverse_pins", {dir, in1, in2}, 3'b101);

      // Stop in reverse keeps the direction
      push_down(1'b1, 100);
      push(ov(1'b0, 1'b1, 1'b0, 8'd0), 0);
      sw = 8'h00;
      drain("stop_rev");

      // Estop during ramp-up: DEAD three edges after assertion, held while high
      push(ov(1'b1, 1'b1, 1'b1, 8'd0), 0);
      push(ov(1'b1, 1'b1, 1'b1, 8'd25), 3);
      push(ov(1'b1, 1'b1, 1'b0, 8'd0), 10 + 2 + DEAD_CYCLES - 3);
      push_up(1'b1, 75);
      sw = 8'h20;
      begin
         int n;
         n = 0;
         while (duty != 8'd25 && n < 200) begin
            @(negedge w5);
            n++;
         end
         check("estop_wait", duty, 25);
      end
      estop = 1'b1;
      repeat (10) @(negedge w5);
      check("estop_dead", outvec, ov(1'b1, 1'b1, 1'b0, 8'd0));
      estop = 1'b0;
      drain("estop");
      check("estop_resume", outvec, ov(1'b0, 1'b1, 1'b1, 8'd75));

      // Asynchronous reset mid-HOLD at 75
      push(13'd0, 0);
      #2;
      sw  = 8'h00;
      u18 = 1'b1;
      #1 check("async_reset", outvec, 0);
      repeat (2) @(negedge w5);
      u18 = 1'b0;
      repeat (20) @(negedge w5);
      check("idle_post_reset", outvec, 0);
      drain("reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/motor_dir_sequencer.md
# motor_dir_sequencer

Sequences single-motor speed and direction for the L298 bridge on PMOD JC. Eight slide-switch requests are synchronised and priority-encoded into a duty target and direction. The block ramps the duty command fed to the PWM generator and flips the bridge direction pins only after a ramp to zero and an enforced dead time. It sits between the switch inputs and the PWM/bridge outputs.

## Interface
- RAMP_DIV, 100000: clock cycles per ramp tick (1 ms at 100 MHz).
- RAMP_STEP, 5: duty percent change per tick.
- DEAD_CYCLES, 100000: cycles with the bridge disabled between direction changes and before stop.
- w5  in  1  100 MHz system clock; all flops rise on it.
- u18  in  1  reset, asynchronous, active-high (btnC).
- sw  in  8  switch requests: [0..3] forward 100/75/50/25 %, [4..7] reverse 100/75/50/25 %.
- estop  in  1  emergency stop, level-sensitive, active-high.
- duty  out  8  duty command in percent (0..100) to the PWM generator.
- en_a  out  1  bridge enable for motor A.
- in1  out  1  L298 IN1.
- in2  out  1  L298 IN2.
- dir  out  1  current applied direction: 0 = forward, 1 = reverse.
- busy  out  1  high in RAMP and DEAD.

## Operation
- Synchronisers: sw and estop each pass through 2 flops. All decisions use the synchronised values.
- Priority encoding: the lowest set index wins, giving req_duty and req_dir. With no switch set, req_duty = 0 and req_dir = dir.
- Prescaler: counts 0..RAMP_DIV-1 from reset and wraps. tick = (count == RAMP_DIV-1). It is free-running and independent of state.
- goal = req_duty if req_dir == dir, else 0.
- State IDLE: duty = 0, en_a = 0, in1 = in2 = 0.
  - If req_duty != 0: dir <= req_dir, go to RAMP.
- State RAMP: en_a = 1, in1 = ~dir, in2 = dir.
  - On tick, duty moves RAMP_STEP toward goal and saturates at goal, with no overshoot and no underflow.
  - If duty == goal and goal != 0: go to HOLD.
  - If duty == 0 and goal == 0: go to DEAD. This check is evaluated every cycle, not only on tick.
- State HOLD: en_a = 1, in1 and in2 as in RAMP, duty constant.
  - If goal != duty: go to RAMP.
- State DEAD: duty = 0, en_a = 0, in1 = in2 = 0. A counter loads DEAD_CYCLES on entry, so the block stays exactly DEAD_CYCLES cycles. On expiry:
  - If req_duty == 0: go to IDLE.
  - Otherwise: dir <= req_dir, go to RAMP.
- estop (synchronised) high, from any state:
  - Next edge: duty <= 0, state <= DEAD.
  - The dead counter is held at DEAD_CYCLES while estop is high; the countdown starts after release.
- in1 and in2 are never both 1. Direction changes only on the DEAD→RAMP or IDLE→RAMP transition.

## Timing
- Reset values: state IDLE, duty 0, en_a 0, in1 0, in2 0, dir 0, busy 0, prescaler 0, dead counter 0, sync flops 0.
- Outputs are registered; state, duty and the bridge pins update on the same edge.
- Switch-to-reaction latency is 2 sync cycles. The state change is visible on the 3rd edge after sw changes.
- Ramp 0→100 at defaults takes 20 ticks (20 ms), plus up to RAMP_DIV-1 cycles of phase to the first tick.
- A request change during RAMP retargets immediately. If a reversal arrives mid ramp-up, the block ramps down from the current duty.
- A request that toggles back during DEAD does not shorten DEAD.
- Reset mid-operation drops all outputs to 0 asynchronously.

## Test plan
Test parameters: RAMP_DIV = 4, RAMP_STEP = 25, DEAD_CYCLES = 8.
- **Reset**: assert u18 mid-HOLD at duty 75 → duty, en_a, in1, in2, dir and busy all 0 immediately. After release, IDLE with sw = 0.
- **Forward ramp**: sw = 8'h01 → IDLE→RAMP on the 3rd edge with in1 = 1, in2 = 0, en_a = 1. Duty goes 25, 50, 75, 100 on successive ticks, then HOLD with busy = 0.
- **Reversal**: from HOLD at forward 100, set sw = 8'h10 → duty 75, 50, 25, 0 on ticks. Then DEAD for exactly 8 cycles with en_a = in1 = in2 = 0. Then dir = 1, in2 = 1, ramp to 100.
- **Priority and partial ramp**: sw = 8'h03 → target 100. Then sw = 8'h08 → ramp down to 25 and HOLD in forward, with no DEAD.
- **Stop and estop**: sw = 0 from 50 → ramp to 0, DEAD 8 cycles, IDLE. With estop high during ramp-up → duty 0 the next edge after sync; DEAD holds while estop is high; resumes ramp 8 cycles after release.
